// File: rtl/multdiv_check_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_check_pkg
//  Description : Shared types and mod-3 helpers for the multiply/divide
//                residue checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package multdiv_check_pkg;

    localparam int c_RES_W = 2;

    typedef logic [c_RES_W-1:0] res_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        CHECK  = 2'd2,
        REPORT = 2'd3
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    // Sum of two residues in 0..2, folded back into 0..2.
    function automatic res_t mod3_add(input res_t a, input res_t b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // Product of two residues in 0..2 (raw product at most 4), folded into 0..2.
    function automatic res_t mod3_mul(input res_t a, input res_t b);
        logic [3:0] p;
        p = {2'b00, a} * {2'b00, b};
        if (p >= 4'd3) begin
            p = p - 4'd3;
        end
        return p[1:0];
    endfunction

endpackage : multdiv_check_pkg
`default_nettype wire

// File: rtl/mod3_residue.sv
`default_nettype none
// ============================================================================
//  Module      : mod3_residue
//  Description : Combinational signed mod-3 residue of a two's-complement
//                value. Base-4 digits are summed in a pairwise tree (4 == 1
//                mod 3), then the sign bit is subtracted (2^n == 1 mod 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module mod3_residue
    import multdiv_check_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    output logic [1:0]       residue
);

    localparam int c_DIGITS = WIDTH / 2;

    // Heap-ordered tree: leaves at c_DIGITS-1 .. 2*c_DIGITS-2, root at 0.
    res_t w_node [0:2*c_DIGITS-2];
    res_t w_unsigned_res;

    // Fold each 2-bit digit into 0..2, then reduce pairwise towards the root.
    always_comb begin
        for (int i = 0; i < c_DIGITS; i++) begin
            w_node[c_DIGITS-1+i] = (value[2*i +: 2] == 2'd3) ? 2'd0 : value[2*i +: 2];
        end
        for (int j = c_DIGITS - 2; j >= 0; j--) begin
            w_node[j] = mod3_add(w_node[2*j+1], w_node[2*j+2]);
        end
        w_unsigned_res = w_node[0];
    end

    // Negative values: subtracting 1 is the same as adding 2 modulo 3.
    assign residue = value[WIDTH-1] ? mod3_add(w_unsigned_res, 2'd2) : w_unsigned_res;

endmodule : mod3_residue
`default_nettype wire

// File: rtl/multdiv_residue_checker.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_residue_checker
//  Description : Concurrent mod-3 residue checker for the multiply/divide
//                unit. Snoops issue, waits for result-ready, then reports
//                pass / fault / skip / timeout with saturating fault count.
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_residue_checker
    import multdiv_check_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int COUNT_W        = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        data_operandA,
    input  logic [15:0]        data_operandB,
    input  logic               ctrl_MULT,
    input  logic               ctrl_DIV,
    input  logic [31:0]        data_result,
    input  logic [31:0]        out_remainder,
    input  logic               data_exception,
    input  logic               data_resultRDY,
    output logic               check_busy,
    output logic               check_valid,
    output logic               check_skipped,
    output logic               fault_detected,
    output logic               timeout,
    output logic               fault_sticky,
    output logic [COUNT_W-1:0] fault_count
);

    localparam int                 c_TMR_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_next;
    op_t                  r_op;
    logic [31:0]          r_opa;
    logic [15:0]          r_opb;
    logic [c_TMR_W-1:0]   r_timer;
    res_t                 r_res_a, r_res_b, r_res_q, r_res_r;
    logic                 r_exc, r_b_zero;
    logic                 r_skip, r_fault, r_timeout, r_sticky;
    logic [COUNT_W-1:0]   r_count;

    res_t                 w_res_a, w_res_b, w_res_q, w_res_r;
    logic                 w_mult_issue, w_div_issue, w_issue;
    logic                 w_timer_done, w_to_report, w_from_timeout;
    logic                 w_skip, w_mismatch, w_new_fault;

    // Exactly one issue control qualifies as an issue; both high is ignored.
    assign w_mult_issue   = ctrl_MULT & ~ctrl_DIV;
    assign w_div_issue    = ctrl_DIV & ~ctrl_MULT;
    assign w_issue        = w_mult_issue | w_div_issue;
    assign w_timer_done   = (r_timer == c_TMR_LAST);
    assign w_to_report    = (w_state_next == REPORT);
    assign w_from_timeout = (r_state == WAIT);

    mod3_residue #(.WIDTH(32)) u_res_a (.value(r_opa),         .residue(w_res_a));
    mod3_residue #(.WIDTH(16)) u_res_b (.value(r_opb),         .residue(w_res_b));
    mod3_residue #(.WIDTH(32)) u_res_q (.value(data_result),   .residue(w_res_q));
    mod3_residue #(.WIDTH(32)) u_res_r (.value(out_remainder), .residue(w_res_r));

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a fresh issue in any busy state restarts tracking.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_issue) w_state_next = WAIT;
            end
            WAIT: begin
                if (w_issue)             w_state_next = WAIT;
                else if (data_resultRDY) w_state_next = CHECK;
                else if (w_timer_done)   w_state_next = REPORT;
            end
            CHECK: begin
                w_state_next = w_issue ? WAIT : REPORT;
            end
            REPORT: begin
                w_state_next = w_issue ? WAIT : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture on issue, timer, and residue capture on first ready.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op     <= OP_MULT;
            r_opa    <= '0;
            r_opb    <= '0;
            r_timer  <= '0;
            r_res_a  <= '0;
            r_res_b  <= '0;
            r_res_q  <= '0;
            r_res_r  <= '0;
            r_exc    <= 1'b0;
            r_b_zero <= 1'b0;
        end else if (w_issue) begin
            r_opa   <= data_operandA;
            r_opb   <= data_operandB;
            r_op    <= w_mult_issue ? OP_MULT : OP_DIV;
            r_timer <= '0;
        end else if (r_state == WAIT) begin
            r_timer <= r_timer + 1'b1;
            if (data_resultRDY) begin
                r_res_a  <= w_res_a;
                r_res_b  <= w_res_b;
                r_res_q  <= w_res_q;
                r_res_r  <= w_res_r;
                r_exc    <= data_exception;
                r_b_zero <= (r_opb == 16'd0);
            end
        end
    end

    // Residue comparison on the captured values.
    always_comb begin
        w_skip     = r_exc | ((r_op == OP_DIV) & r_b_zero);
        w_mismatch = 1'b0;
        if (r_op == OP_MULT) begin
            w_mismatch = (mod3_mul(r_res_a, r_res_b) != r_res_q);
        end else begin
            w_mismatch = (mod3_add(mod3_mul(r_res_q, r_res_b), r_res_r) != r_res_a);
        end
    end

    assign w_new_fault = w_to_report & (w_from_timeout | (~w_skip & w_mismatch));

    // Verdict register and fault accounting, updated as REPORT is entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_skip    <= 1'b0;
            r_fault   <= 1'b0;
            r_timeout <= 1'b0;
            r_sticky  <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_to_report) begin
                r_timeout <= w_from_timeout;
                r_skip    <= ~w_from_timeout & w_skip;
                r_fault   <= w_from_timeout | (~w_skip & w_mismatch);
            end
            if (w_new_fault) begin
                r_sticky <= 1'b1;
                if (r_count != {COUNT_W{1'b1}}) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign check_busy     = (r_state != IDLE);
    assign check_valid    = (r_state == REPORT);
    assign check_skipped  = check_valid & r_skip;
    assign fault_detected = check_valid & r_fault;
    assign timeout        = check_valid & r_timeout;
    assign fault_sticky   = r_sticky;
    assign fault_count    = r_count;

endmodule : multdiv_residue_checker
`default_nettype wire

// File: tb/tb_multdiv_residue_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv_residue_checker
//  Description : Self-checking bench for multdiv_residue_checker with an
//                arithmetic reference model and randomized operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_residue_checker;

    localparam int c_TIMEOUT = 64;
    localparam int c_CNT_W   = 16;

    logic               clock;
    logic               reset;
    logic [31:0]        data_operandA;
    logic [15:0]        data_operandB;
    logic               ctrl_MULT;
    logic               ctrl_DIV;
    logic [31:0]        data_result;
    logic [31:0]        out_remainder;
    logic               data_exception;
    logic               data_resultRDY;
    logic               check_busy;
    logic               check_valid;
    logic               check_skipped;
    logic               fault_detected;
    logic               timeout;
    logic               fault_sticky;
    logic [c_CNT_W-1:0] fault_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_mult;
    logic [31:0] m_a;
    logic [15:0] m_b;
    logic [31:0] m_res;
    logic [31:0] m_rem;
    bit          m_exc;
    int          m_count;
    bit          m_sticky;

    multdiv_residue_checker #(
        .TIMEOUT_CYCLES(c_TIMEOUT),
        .COUNT_W       (c_CNT_W)
    ) u_dut (
        .clock         (clock),
        .reset         (reset),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_result   (data_result),
        .out_remainder (out_remainder),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .check_busy    (check_busy),
        .check_valid   (check_valid),
        .check_skipped (check_skipped),
        .fault_detected(fault_detected),
        .timeout       (timeout),
        .fault_sticky  (fault_sticky),
        .fault_count   (fault_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int m3(input longint v);
        return int'(((v % 3) + 3) % 3);
    endfunction

    // Verdict from plain signed arithmetic on the values the unit presented.
    function automatic void model_verdict(output bit skip, output bit fault);
        longint sa, sb, sq, sr;
        sa = longint'($signed(m_a));
        sb = longint'($signed(m_b));
        sq = longint'($signed(m_res));
        sr = longint'($signed(m_rem));
        if (m_mult) begin
            skip  = m_exc;
            fault = !skip && (m3(sa * sb) != m3(sq));
        end else begin
            skip  = m_exc || (sb == 0);
            fault = !skip && (m3(sa) != m3(sq * sb + sr));
        end
    endfunction

    function automatic void model_fault();
        m_sticky = 1'b1;
        if (m_count != (1 << c_CNT_W) - 1) m_count++;
    endfunction

    task automatic issue(input bit mult, input logic [31:0] a, input logic [15:0] b);
        data_operandA  = a;
        data_operandB  = b;
        ctrl_MULT      = mult;
        ctrl_DIV       = !mult;
        data_resultRDY = 1'b0;
        m_mult = mult;
        m_a    = a;
        m_b    = b;
        tick();
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic respond(input logic [31:0] res, input logic [31:0] rem, input bit exc, input int delay);
        for (int i = 0; i < delay; i++) tick();
        data_result    = res;
        out_remainder  = rem;
        data_exception = exc;
        data_resultRDY = 1'b1;
        m_res = res;
        m_rem = rem;
        m_exc = exc;
        tick();
        data_resultRDY = 1'b0;
    endtask

    // Called in the cycle after ready: verdict must appear exactly one cycle later.
    task automatic expect_verdict(input string tag);
        bit e_skip, e_fault;
        model_verdict(e_skip, e_fault);
        if (e_fault) model_fault();
        check_value({tag, "_early"}, check_valid, 1'b0);
        tick();
        check_value({tag, "_valid"}, check_valid, 1'b1);
        check_value({tag, "_skip"},  check_skipped, e_skip);
        check_value({tag, "_fault"}, fault_detected, e_fault);
        check_value({tag, "_tmo"},   timeout, 1'b0);
        check_value({tag, "_count"}, fault_count, m_count);
        check_value({tag, "_sticky"}, fault_sticky, m_sticky);
        tick();
        check_value({tag, "_drop"}, check_valid, 1'b0);
        check_value({tag, "_idle"}, check_busy, 1'b0);
    endtask

    initial begin
        bit          mul;
        logic [31:0] a, res, rem;
        logic [15:0] b;
        bit          exc;
        longint      p, q, r;
        int          n;

        reset = 1'b1;
        data_operandA = '0; data_operandB = '0;
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_result = '0; out_remainder = '0;
        data_exception = 1'b0; data_resultRDY = 1'b0;
        m_count = 0; m_sticky = 1'b0;
        tick(); tick();
        check_value("rst_valid",  check_valid, 1'b0);
        check_value("rst_busy",   check_busy, 1'b0);
        check_value("rst_sticky", fault_sticky, 1'b0);
        check_value("rst_count",  fault_count, 0);
        reset = 1'b0;
        tick();

        // Directed cases
        issue(1'b1, 32'd7, 16'd6);
        check_value("issue_busy", check_busy, 1'b1);
        respond(32'd42, 32'd0, 1'b0, 5);  expect_verdict("mul_pass");
        issue(1'b1, 32'd7, 16'd6);
        respond(32'd43, 32'd0, 1'b0, 2);  expect_verdict("mul_fault");
        issue(1'b0, 32'd100, 16'd7);
        respond(32'd14, 32'd2, 1'b0, 3);  expect_verdict("div_pass");
        issue(1'b0, 32'd100, 16'd7);
        respond(32'd15, 32'd2, 1'b0, 1);  expect_verdict("div_fault");
        issue(1'b1, -32'sd9, 16'd5);
        respond(-32'sd45, 32'd0, 1'b0, 0); expect_verdict("mul_signed");
        issue(1'b0, 32'd100, 16'd0);
        respond(32'hFFFF_FFFF, 32'd100, 1'b1, 2); expect_verdict("div_zero");
        issue(1'b1, 32'h4000_0000, 16'h4000);
        respond(32'd0, 32'd0, 1'b1, 2);   expect_verdict("mul_ovf");

        // Timeout: the timer covers TIMEOUT WAIT cycles before the report.
        issue(1'b1, 32'd3, 16'd3);
        n = 0;
        while (check_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        model_fault();
        check_value("tmo_latency", n, c_TIMEOUT);
        check_value("tmo_flag",   timeout, 1'b1);
        check_value("tmo_fault",  fault_detected, 1'b1);
        check_value("tmo_skip",   check_skipped, 1'b0);
        check_value("tmo_count",  fault_count, m_count);
        tick();
        check_value("tmo_drop",   check_valid, 1'b0);

        // Both issue controls high: ignored
        data_operandA = 32'd5; data_operandB = 16'd5;
        ctrl_MULT = 1'b1; ctrl_DIV = 1'b1;
        tick();
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        check_value("both_busy", check_busy, 1'b0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (check_valid === 1'b1 || check_busy === 1'b1) n++;
        end
        check_value("both_quiet", n, 0);

        // Re-issue during CHECK: only the new operation yields a verdict
        issue(1'b1, 32'd7, 16'd6);
        respond(32'd43, 32'd0, 1'b0, 2);
        issue(1'b1, 32'd3, 16'd5);
        check_value("reiss_valid", check_valid, 1'b0);
        check_value("reiss_busy",  check_busy, 1'b1);
        respond(32'd15, 32'd0, 1'b0, 1);  expect_verdict("reiss");

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            mul = 1'($urandom_range(0, 1));
            a   = $urandom;
            if ($urandom_range(0, 1) == 1) a = 32'($signed(int'($urandom_range(0, 2000)) - 1000));
            b   = 16'($urandom);
            if ($urandom_range(0, 7) == 0) b = 16'd0;
            rem = 32'd0;
            exc = 1'b0;
            if (mul) begin
                p   = longint'($signed(a)) * longint'($signed(b));
                res = p[31:0];
                exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
            end else if (b == 16'd0) begin
                res = 32'hFFFF_FFFF;
                rem = a;
                exc = 1'b1;
            end else begin
                q   = longint'($signed(a)) / longint'($signed(b));
                r   = longint'($signed(a)) % longint'($signed(b));
                res = q[31:0];
                rem = r[31:0];
            end
            if ($urandom_range(0, 3) == 0) res = res ^ (32'd1 << $urandom_range(0, 31));
            issue(mul, a, b);
            respond(res, rem, exc, int'($urandom_range(0, 6)));
            expect_verdict("rand");
        end

        // Asynchronous reset in the middle of WAIT
        issue(1'b0, 32'd9, 16'd2);
        tick();
        reset = 1'b1;
        #1;
        m_count = 0; m_sticky = 1'b0;
        check_value("arst_busy",   check_busy, 1'b0);
        check_value("arst_valid",  check_valid, 1'b0);
        check_value("arst_count",  fault_count, 0);
        check_value("arst_sticky", fault_sticky, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        issue(1'b0, 32'd9, 16'd2);
        respond(32'd4, 32'd1, 1'b0, 1);   expect_verdict("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_multdiv_residue_checker
`default_nettype wire
